// File: rtl/fp13_pkg.sv
// rtl/fp13_pkg.sv - 13-bit float field layout and max-finder state encoding
package fp13_pkg;

    localparam int FP_W   = 13;
    localparam int EXP_W  = 4;
    localparam int MANT_W = 8;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp13_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } smax_state_t;

endpackage

// File: rtl/fp_greater_than.sv
// rtl/fp_greater_than.sv - combinational strict fp1 > fp2 for 13-bit floats
module fp_greater_than
    import fp13_pkg::*;
(
    input  logic [FP_W-1:0] fp1,
    input  logic [FP_W-1:0] fp2,
    output logic            gt
);

    fp13_t                     a;
    fp13_t                     b;
    logic [EXP_W+MANT_W-1:0]   mag_a;
    logic [EXP_W+MANT_W-1:0]   mag_b;

    always_comb begin
        a     = fp13_t'(fp1);
        b     = fp13_t'(fp2);
        mag_a = {a.exp, a.mant};
        mag_b = {b.exp, b.mant};
        // Sign decides first, so +0 ranks above -0; negatives order by smaller magnitude.
        if (a.sign != b.sign) begin
            gt = !a.sign;
        end else if (a.sign) begin
            gt = (mag_a < mag_b);
        end else begin
            gt = (mag_a > mag_b);
        end
    end

endmodule

// File: rtl/fp_stream_max.sv
// rtl/fp_stream_max.sv - streaming max-finder reporting max value, position and frame length
module fp_stream_max
    import fp13_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_len,
    output logic              out_trunc
);

    localparam logic [IDX_W:0] LAST_CNT = {1'b0, {IDX_W{1'b1}}};
    localparam logic [IDX_W:0] ONE_CNT  = {{IDX_W{1'b0}}, 1'b1};

    smax_state_t        state_q, state_d;
    logic [FP_W-1:0]    max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     count_q, count_d;
    logic               trunc_q, trunc_d;
    logic               beat;
    logic               gt;

    fp_greater_than u_cmp (
        .fp1 (in_data),
        .fp2 (max_q),
        .gt  (gt)
    );

    assign in_ready  = (state_q != HOLD);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_len   = count_q;
    assign out_trunc = trunc_q;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        count_d = count_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    count_d = ONE_CNT;
                    trunc_d = 1'b0;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (gt) begin
                        max_d = in_data;
                        idx_d = count_q[IDX_W-1:0];
                    end
                    count_d = count_q + ONE_CNT;
                    // A frame that fills the index space is closed; trunc marks it had no in_last.
                    if (in_last) begin
                        state_d = HOLD;
                    end else if (count_q == LAST_CNT) begin
                        state_d = HOLD;
                        trunc_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    count_d = '0;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

endmodule

// File: tb/tb_fp_stream_max.sv
// tb/tb_fp_stream_max.sv - randomized and directed bench for fp_stream_max
module tb_fp_stream_max;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [12:0] in_data = '0;
    logic        in_ready, out_valid, out_trunc;
    logic [12:0] out_max;
    logic [7:0]  out_idx;
    logic [8:0]  out_len;

    logic        in_valid3 = 1'b0, in_last3 = 1'b0, out_ready3 = 1'b0;
    logic [12:0] in_data3 = '0;
    logic        in_ready3, out_valid3, out_trunc3;
    logic [12:0] out_max3;
    logic [2:0]  out_idx3;
    logic [3:0]  out_len3;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fp_stream_max #(.IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_idx(out_idx), .out_len(out_len), .out_trunc(out_trunc)
    );

    fp_stream_max #(.IDX_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_last(in_last3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_max(out_max3), .out_idx(out_idx3), .out_len(out_len3), .out_trunc(out_trunc3)
    );

    // Map a value onto an integer whose natural order is the float order (+0 above -0).
    function automatic int fkey(logic [12:0] v);
        return v[12] ? -int'({20'd0, v[11:0]}) - 1 : int'({20'd0, v[11:0]});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame into the IDX_W=8 instance; lat_ok reports bounded acceptance
    // and out_valid present right after the closing beat.
    task automatic send_frame8(input logic [12:0] q[$], input int gaps, output bit lat_ok);
        int n;
        lat_ok = 1'b1;
        foreach (q[i]) begin
            repeat ($urandom_range(0, gaps)) tick();
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = (i == q.size() - 1);
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            if (n == 50) lat_ok = 1'b0;
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        lat_ok = lat_ok && out_valid;
    endtask

    task automatic send_beat3(input logic [12:0] d, input logic last);
        in_valid3 = 1'b1;
        in_data3  = d;
        in_last3  = last;
        tick();
        in_valid3 = 1'b0;
        in_last3  = 1'b0;
    endtask

    task automatic release8();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (out_max !== 13'h0) begin failed++; $display("FAIL reset_max got %h exp 0000", out_max); end
        tests++; if (out_len !== 9'd0) begin failed++; $display("FAIL reset_len got %0d exp 0", out_len); end
        rst_n = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        tests++; if (in_ready3 !== 1'b1) begin failed++; $display("FAIL reset_ready3 got %b exp 1", in_ready3); end
    endtask

    task automatic test_basic();
        bit ok;
        send_frame8('{13'h0340, 13'h0510, 13'h0380}, 0, ok);
        tests++; if (ok !== 1'b1) begin failed++; $display("FAIL basic_latency got %b exp 1", ok); end
        tests++; if (out_max !== 13'h0510) begin failed++; $display("FAIL basic_max got %h exp 0510", out_max); end
        tests++; if (out_idx !== 8'd1) begin failed++; $display("FAIL basic_idx got %0d exp 1", out_idx); end
        tests++; if (out_len !== 9'd3) begin failed++; $display("FAIL basic_len got %0d exp 3", out_len); end
        tests++; if (out_trunc !== 1'b0) begin failed++; $display("FAIL basic_trunc got %b exp 0", out_trunc); end
        release8();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_release got %b exp 0", out_valid); end
    endtask

    task automatic test_negative();
        bit ok;
        send_frame8('{13'h1340, 13'h1210, 13'h1500}, 1, ok);
        tests++; if (ok !== 1'b1) begin failed++; $display("FAIL neg_latency got %b exp 1", ok); end
        tests++; if (out_max !== 13'h1210) begin failed++; $display("FAIL neg_max got %h exp 1210", out_max); end
        tests++; if (out_idx !== 8'd1) begin failed++; $display("FAIL neg_idx got %0d exp 1", out_idx); end
        tests++; if (out_len !== 9'd3) begin failed++; $display("FAIL neg_len got %0d exp 3", out_len); end
        release8();
    endtask

    task automatic test_ties();
        bit ok;
        send_frame8('{13'h0200, 13'h0200}, 0, ok);
        tests++; if (out_idx !== 8'd0) begin failed++; $display("FAIL tie_idx got %0d exp 0", out_idx); end
        tests++; if (out_max !== 13'h0200) begin failed++; $display("FAIL tie_max got %h exp 0200", out_max); end
        release8();
        send_frame8('{13'h1000, 13'h0000}, 0, ok);
        tests++; if (out_max !== 13'h0000) begin failed++; $display("FAIL zero_max got %h exp 0000", out_max); end
        tests++; if (out_idx !== 8'd1) begin failed++; $display("FAIL zero_idx got %0d exp 1", out_idx); end
        release8();
    endtask

    task automatic test_backpressure();
        bit ok;
        send_frame8('{13'h0100, 13'h0200}, 0, ok);
        in_valid = 1'b1;
        in_data  = 13'h0777;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_ready c%0d got %b exp 0", c, in_ready); end
            tests++; if (out_valid !== 1'b1 || out_max !== 13'h0200 || out_idx !== 8'd1 || out_len !== 9'd2)
                begin failed++; $display("FAIL bp_stable c%0d got v%b %h i%0d l%0d exp v1 0200 i1 l2", c, out_valid, out_max, out_idx, out_len); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL bp_idle got v%b r%b exp v0 r1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_max !== 13'h0777 || out_idx !== 8'd0 || out_len !== 9'd1)
            begin failed++; $display("FAIL bp_held_beat got v%b %h i%0d l%0d exp v1 0777 i0 l1", out_valid, out_max, out_idx, out_len); end
        release8();
    endtask

    task automatic test_random();
        logic [12:0] q[$];
        logic [12:0] pool [4] = '{13'h0000, 13'h1000, 13'h0200, 13'h1200};
        int len, best_key, best_idx;
        bit ok;
        for (int f = 0; f < 25; f++) begin
            q.delete();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 13'($urandom_range(0, 8191)));
            best_key = fkey(q[0]);
            foreach (q[i]) if (fkey(q[i]) > best_key) best_key = fkey(q[i]);
            best_idx = -1;
            foreach (q[i]) if (best_idx < 0 && fkey(q[i]) == best_key) best_idx = i;
            send_frame8(q, 2, ok);
            tests++; if (ok !== 1'b1) begin failed++; $display("FAIL rnd%0d_latency got %b exp 1", f, ok); end
            tests++; if (out_max !== q[best_idx]) begin failed++; $display("FAIL rnd%0d_max got %h exp %h", f, out_max, q[best_idx]); end
            tests++; if (out_idx !== 8'(best_idx)) begin failed++; $display("FAIL rnd%0d_idx got %0d exp %0d", f, out_idx, best_idx); end
            tests++; if (out_len !== 9'(len) || out_trunc !== 1'b0) begin failed++; $display("FAIL rnd%0d_len got %0d t%b exp %0d t0", f, out_len, out_trunc, len); end
            repeat ($urandom_range(0, 3)) tick();
            release8();
        end
    endtask

    task automatic test_trunc();
        logic [12:0] d;
        for (int i = 0; i < 8; i++) begin
            d = (i == 5) ? 13'h0F00 : 13'($urandom_range(0, 13'h0EFF)) | (($urandom_range(0, 1) == 1) ? 13'h1000 : 13'h0);
            send_beat3(d, 1'b0);
        end
        tests++; if (out_valid3 !== 1'b1) begin failed++; $display("FAIL trunc_valid got %b exp 1", out_valid3); end
        tests++; if (out_trunc3 !== 1'b1) begin failed++; $display("FAIL trunc_flag got %b exp 1", out_trunc3); end
        tests++; if (out_len3 !== 4'd8) begin failed++; $display("FAIL trunc_len got %0d exp 8", out_len3); end
        tests++; if (out_idx3 !== 3'd5 || out_max3 !== 13'h0F00) begin failed++; $display("FAIL trunc_idx got %0d %h exp 5 0f00", out_idx3, out_max3); end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        tests++; if (out_valid3 !== 1'b0 || out_trunc3 !== 1'b0) begin failed++; $display("FAIL trunc_release got v%b t%b exp v0 t0", out_valid3, out_trunc3); end
    endtask

    task automatic test_reset_midframe();
        send_beat3(13'h0700, 1'b0);
        send_beat3(13'h0650, 1'b0);
        send_beat3(13'h0400, 1'b0);
        #2 rst_n = 1'b0;
        #2;
        tests++; if (out_len3 !== 4'd0 || out_max3 !== 13'h0) begin failed++; $display("FAIL midrst_clear got l%0d %h exp l0 0000", out_len3, out_max3); end
        tick();
        rst_n = 1'b1;
        tick();
        send_beat3(13'h0100, 1'b0);
        send_beat3(13'h0300, 1'b1);
        tests++; if (out_valid3 !== 1'b1 || out_max3 !== 13'h0300 || out_idx3 !== 3'd1 || out_len3 !== 4'd2 || out_trunc3 !== 1'b0)
            begin failed++; $display("FAIL midrst_frame got v%b %h i%0d l%0d t%b exp v1 0300 i1 l2 t0", out_valid3, out_max3, out_idx3, out_len3, out_trunc3); end
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_ties();
        test_backpressure();
        test_random();
        test_trunc();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
